// File: rtl/zbus_mem_s.sv
// zbus_mem_s: memory-backed zbus slave endpoint.
// Requests on the w_* bus read or write an internal synchronous RAM. Read
// responses go through a one-deep pending stage and a 2-entry response FIFO
// so that r_rdy backpressure never loses or corrupts data.
// Optional build macro: ZBUS_MEM_WACK_EN -- when defined, every accepted
// write also returns an acknowledge response {r_aen=1, r_den=0} in request
// order, and writes then count toward response occupancy.
module zbus_mem_s #(
    parameter int WA    = 32,
    parameter int WD    = 32,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_vld,
    input  logic          w_aen,
    input  logic          w_den,
    input  logic [WA-1:0] w_adr,
    input  logic [WD-1:0] w_dat,
    output logic          w_rdy,
    output logic          r_vld,
    output logic          r_aen,
    output logic          r_den,
    output logic [WA-1:0] r_adr,
    output logic [WD-1:0] r_dat,
    input  logic          r_rdy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // FIFO entry layout: {aen, den, adr, dat}
    localparam int EW = 2 + WA + WD;

    logic [WD-1:0] mem [DEPTH];

    logic [WA-1:0] ptr;
    logic [WA-1:0] ea;
    logic [AW-1:0] idx;
    logic          w_xfer;
    logic          resp_req;

    logic          pend;
    logic          pend_aen;
    logic          pend_den;
    logic [WA-1:0] pend_adr;
    logic [WD-1:0] rd_dat;

    logic [1:0]    cnt;
    logic [1:0]    occ;
    logic [EW-1:0] slot0;
    logic [EW-1:0] slot1;
    logic [EW-1:0] push_ent;
    logic          push;
    logic          pop;
    logic          load0;
    logic          load1;

    assign ea     = w_aen ? w_adr : ptr;
    // Upper address bits are ignored, so addresses alias every DEPTH words.
    assign idx    = ea[AW-1:0];
    assign w_xfer = w_vld & w_rdy;

`ifdef ZBUS_MEM_WACK_EN
    assign resp_req = w_xfer;
`else
    assign resp_req = w_xfer & ~w_den;
`endif

    // Occupancy counts the pending stage as well as the FIFO, so an accepted
    // request always has a FIFO slot waiting for it one edge later. The
    // r_rdy term lets a pop free a slot in the same cycle for full throughput.
    assign occ   = cnt + {1'b0, pend};
    assign pop   = r_vld & r_rdy;
    assign w_rdy = rst & ((occ < 2'd2) | pop);

    assign push     = pend;
    assign push_ent = {pend_aen, pend_den, pend_adr, (pend_den ? rd_dat : {WD{1'b0}})};
    // New entry lands in slot0 if the FIFO is (or is becoming) empty.
    assign load0    = push & ((cnt == 2'd0) | ((cnt == 2'd1) & pop));
    assign load1    = push & ~load0;

    assign r_vld = (cnt != 2'd0);
    assign r_aen = slot0[EW-1];
    assign r_den = slot0[EW-2];
    assign r_adr = slot0[WD +: WA];
    assign r_dat = slot0[WD-1:0];

    // RAM: write at the transfer edge, synchronous read into rd_dat.
    always_ff @(posedge clk) begin
        if (w_xfer & w_den) begin
            mem[idx] <= w_dat;
        end
        if (w_xfer & ~w_den) begin
            rd_dat <= mem[idx];
        end
    end

    // Burst pointer and pending-response stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr      <= '0;
            pend     <= 1'b0;
            pend_aen <= 1'b0;
            pend_den <= 1'b0;
            pend_adr <= '0;
        end else begin
            if (w_xfer) begin
                ptr <= ea + WA'(1);
            end
            pend <= resp_req;
            if (resp_req) begin
                pend_aen <= w_den;
                pend_den <= ~w_den;
                pend_adr <= ea;
            end
        end
    end

    // Two-entry response FIFO; slot0 is the head and drives r_* directly,
    // so the head only changes on a pop or when the FIFO is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (pop && (cnt == 2'd2)) begin
                slot0 <= slot1;
            end
            if (load0) begin
                slot0 <= push_ent;
            end
            if (load1) begin
                slot1 <= push_ent;
            end
            if (push && !pop) begin
                cnt <= cnt + 2'd1;
            end else if (!push && pop) begin
                cnt <= cnt - 2'd1;
            end
        end
    end

endmodule
